pipe_stage_reg: RTL

- Parametrised pipeline stage register for the ARM core pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries).
- Successor to the fixed-field stage registers. Carries an opaque data bundle plus a control bundle (wb_en, mem_r_en, mem_w_en, B, S, ...), adds a valid/ready handshake, an optional 2-entry skid buffer for full-throughput stalls, flush with control squashing, and a saturating count of squashed instructions.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_stage_reg
// Brief   : Valid/ready pipeline stage register with an optional skid entry,
//           flush with control squashing and a saturating squash counter.
// Rev     : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int DATA_W  = 128,
  parameter int CTRL_W  = 8,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  squash_cnt
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_main_data;
  logic [CTRL_W-1:0]  r_main_ctrl;
  logic [DATA_W-1:0]  r_skid_data;
  logic [CTRL_W-1:0]  r_skid_ctrl;
  logic [CNT_W-1:0]   r_squash;

  logic               w_main_valid;
  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_ld_main_in;
  logic               w_ld_main_skid;
  logic               w_ld_skid;
  logic [1:0]         w_discard;
  logic [CNT_W:0]     w_squash_sum;
  logic [CNT_W-1:0]   w_squash_nxt;

  assign w_main_valid = (r_state != ST_EMPTY);
  assign w_in_xfer    = in_valid & w_in_ready;
  assign w_out_xfer   = w_main_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_xfer && (SKID_EN != 0)) begin
          w_ld_skid   = 1'b1;
          w_state_nxt = ST_TWO;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_xfer) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // An entry handed downstream on the flush edge is not a squashed entry.
  assign w_discard    = r_state - {1'b0, w_out_xfer};
  assign w_squash_sum = {1'b0, r_squash} + (CNT_W+1)'(w_discard);
  assign w_squash_nxt = w_squash_sum[CNT_W] ? {CNT_W{1'b1}} : w_squash_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
      r_squash    <= '0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      r_squash    <= w_squash_nxt;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_main_in) begin
        r_main_data <= in_data;
        r_main_ctrl <= in_ctrl;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_ld_skid) begin
        r_skid_data <= in_data;
        r_skid_ctrl <= in_ctrl;
      end
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      // Registered ready: no combinational path from out_ready.
      logic r_in_ready;
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_TWO);
        end
      end
      assign w_in_ready = r_in_ready;
    end else begin : g_single
      assign w_in_ready = !w_main_valid | out_ready;
    end
  endgenerate

  assign in_ready   = w_in_ready;
  assign out_valid  = w_main_valid;
  assign out_data   = r_main_data;
  assign out_ctrl   = r_main_ctrl & {CTRL_W{w_main_valid}};
  assign occupancy  = r_state;
  assign squash_cnt = r_squash;

endmodule
`default_nettype wire
